if_fetch: RTL and testbench

- Instruction-fetch stage of the 5-stage RISC-V pipeline.
- Owns the PC and assembles 32-bit little-endian instructions from a byte-wide memory port using a request/grant/valid handshake.
- Presents {pc, inst, valid} to the IF/ID pipeline register.
- Consumes stall[0] (PC keep) and stall[1] (IF stall) from the stall controller, and branch redirects from ID.
- Raises stallreq_from_if while an instruction is still being assembled.

---
 rtl/if_fetch_pkg.sv | 29 ++
 rtl/if_fetch_if.sv | 40 ++++
 rtl/if_fetch.sv | 150 +++++++++++++++
 tb/tb_if_fetch.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_pkg
// Purpose  : Shared defines for the instruction-fetch stage: reset/stall
//            polarities, bus widths, stall bit indices and the fetch FSM
//            state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package if_fetch_pkg;

  localparam logic        RstEnable   = 1'b1;
  localparam logic        Stop        = 1'b1;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam int          InstAddrBus = 31;
  localparam int          InstBus     = 31;

  // Bit positions inside the 6-bit stall vector {wb,mem,ex,id,if,pc}
  localparam int          STALL_PC    = 0;
  localparam int          STALL_IF    = 1;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/if_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_if
// Purpose  : Byte-wide instruction memory port (request / grant / rvalid).
// Signals  : mem_req_o    fetch -> mem  byte read request
//            mem_addr_o   fetch -> mem  byte address of the request
//            mem_gnt_i    mem -> fetch  request accepted this cycle
//            mem_rvalid_i mem -> fetch  read data valid
//            mem_rdata_i  mem -> fetch  read byte
// Modports : master (fetch stage), slave (memory)
// Revision : 1.0 - initial release
// ============================================================================
interface if_fetch_if #(
  parameter int ADDR_W = 32
);

  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [7:0]        mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_gnt_i,
    input  mem_rvalid_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_gnt_i,
    output mem_rvalid_i,
    output mem_rdata_i
  );

endinterface
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Purpose  : Instruction-fetch stage. Owns the PC and assembles 32-bit
//            little-endian instructions one byte at a time from a byte-wide
//            memory port, then presents {pc, inst, valid} to IF/ID.
// Ports    : clk              rising-edge clock
//            rst              synchronous active-high reset
//            stall[5:0]       {wb,mem,ex,id,if,pc}; bit0 keeps PC, bit1 stalls IF
//            branch_flag_i    redirect pulse from ID
//            branch_target_i  redirect target (low 2 bits ignored)
//            mem              byte memory port (master side)
//            if_pc_o          PC of the presented instruction
//            if_inst_o        assembled instruction
//            if_valid_o       pc/inst form a complete fetched instruction
//            stallreq_from_if high while an instruction is being assembled
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int                ADDR_W   = InstAddrBus + 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic [5:0]        stall,
  input  wire logic              branch_flag_i,
  input  wire logic [ADDR_W-1:0] branch_target_i,
  if_fetch_if.master             mem,
  output logic [ADDR_W-1:0]      if_pc_o,
  output logic [InstBus:0]       if_inst_o,
  output logic                   if_valid_o,
  output logic                   stallreq_from_if
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q,    pc_d;
  logic [1:0]        cnt_q,   cnt_d;
  logic [InstBus:0]  buf_q,   buf_d;

  // Low for the first cycle after reset so every output reads zero there;
  // the request is only raised once this flag is set.
  logic              run_q;

  logic              req_active;
  logic              granted;
  logic              presenting;

  // Upper stall bits belong to later stages; target bits [1:0] are forced
  // to zero on redirect.
  logic              stall_unused;
  assign stall_unused = ^{stall[5:2], branch_target_i[1:0]};

  assign req_active = run_q && (state_q == REQ);
  assign granted    = req_active && mem.mem_gnt_i;
  assign presenting = (state_q == HOLD);

  // --------------------------------------------------------------------------
  // State / datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      cnt_q   <= 2'd0;
      buf_q   <= ZeroWord;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      run_q   <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;

    case (state_q)
      REQ: begin
        if (granted) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem.mem_rvalid_i) begin
          buf_d[{cnt_q, 3'b000} +: 8] = mem.mem_rdata_i;
          if (cnt_q == 2'd3) begin
            state_d = HOLD;
          end else begin
            cnt_d   = cnt_q + 2'd1;
            state_d = REQ;
          end
        end
      end
      HOLD: begin
        // IF stalled, or PC kept: keep presenting the same instruction.
        if ((stall[STALL_IF] != Stop) && (stall[STALL_PC] != Stop)) begin
          pc_d    = pc_q + ADDR_W'(4);
          cnt_d   = 2'd0;
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (mem.mem_rvalid_i) begin
          cnt_d   = 2'd0;
          state_d = REQ;
        end
      end
      default: begin
        state_d = REQ;
      end
    endcase

    // A redirect overrides everything above. A request the memory has already
    // accepted must still have its response swallowed, hence DRAIN.
    if (branch_flag_i) begin
      pc_d  = {branch_target_i[ADDR_W-1:2], 2'b00};
      cnt_d = 2'd0;
      buf_d = buf_q;
      case (state_q)
        REQ:         state_d = granted ? DRAIN : REQ;
        WAIT, DRAIN: state_d = mem.mem_rvalid_i ? REQ : DRAIN;
        default:     state_d = REQ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mem.mem_req_o  = req_active;
  assign mem.mem_addr_o = req_active ? (pc_q + {{(ADDR_W-2){1'b0}}, cnt_q}) : '0;

  assign if_valid_o       = presenting;
  assign if_pc_o          = presenting ? pc_q  : '0;
  assign if_inst_o        = presenting ? buf_q : ZeroWord;
  assign stallreq_from_if = run_q && ((state_q == REQ) || (state_q == WAIT))
                            && !branch_flag_i;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch
// Purpose  : Self-checking bench for if_fetch: table of directed fetches,
//            hand-written multi-cycle corner cases, then randomized traffic
//            against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;
  logic        stallreq_from_if;

  always #5 clk = ~clk;

  if_fetch_if #(.ADDR_W(32)) mif ();

  if_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .mem             (mif),
    .if_pc_o         (if_pc_o),
    .if_inst_o       (if_inst_o),
    .if_valid_o      (if_valid_o),
    .stallreq_from_if(stallreq_from_if)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory contents ----------------
  logic [7:0] mem [0:255];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] t0, t1, t2, t3;
    t0 = a; t1 = a + 1; t2 = a + 2; t3 = a + 3;
    return {mem[t3[7:0]], mem[t2[7:0]], mem[t1[7:0]], mem[t0[7:0]]};
  endfunction

  // ---------------- memory responder ----------------
  int   d_gnt_wait = 0;
  int   d_lat      = 0;
  bit   rand_mode  = 0;
  bit   r_pending  = 0;
  bit   r_seen     = 0;
  int   r_lat      = 0;
  int   r_wait     = 0;
  logic [31:0] r_addr = '0;

  initial begin
    mif.mem_gnt_i    = 1'b0;
    mif.mem_rvalid_i = 1'b0;
    mif.mem_rdata_i  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      mif.mem_gnt_i    = 1'b0;
      mif.mem_rvalid_i = 1'b0;
      if (rst === 1'b1) begin
        r_pending = 0;
        r_seen    = 0;
      end else if (r_pending) begin
        if (r_lat == 0) begin
          mif.mem_rvalid_i = 1'b1;
          mif.mem_rdata_i  = mem[r_addr[7:0]];
          r_pending        = 0;
        end else begin
          r_lat--;
        end
      end else if (mif.mem_req_o === 1'b1) begin
        if (!r_seen) begin
          r_seen = 1;
          r_wait = rand_mode ? int'($urandom_range(0, 3)) : d_gnt_wait;
        end
        if (r_wait == 0) begin
          mif.mem_gnt_i = 1'b1;
          r_addr        = mif.mem_addr_o;
          r_pending     = 1;
          r_seen        = 0;
          r_lat         = rand_mode ? int'($urandom_range(0, 2)) : d_lat;
        end else begin
          r_wait--;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input logic [5:0] st, input logic br, input logic [31:0] tg, input logic rs);
    @(negedge clk);
    stall           = st;
    branch_flag_i   = br;
    branch_target_i = tg;
    rst             = rs;
    #1;
  endtask

  task automatic check_zero(input string name);
    check({name, "_ctl"}, {61'd0, mif.mem_req_o, if_valid_o, stallreq_from_if}, 64'd0);
    check({name, "_data"}, {32'd0, mif.mem_addr_o | if_pc_o | if_inst_o}, 64'd0);
  endtask

  task automatic wait_valid(input string name, input logic [5:0] st,
                            input logic [31:0] exp_pc);
    bit found;
    found = 0;
    for (int k = 0; k < 200; k++) begin
      tick(st, 1'b0, 32'h0, 1'b0);
      if (if_valid_o === 1'b1) begin
        found = 1;
        break;
      end
    end
    check({name, "_found"}, found, 1);
    check({name, "_pc"}, if_pc_o, exp_pc);
    check({name, "_inst"}, if_inst_o, word_at(exp_pc));
  endtask

  typedef struct {
    int          gnt_wait;
    int          lat;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    int          exp_cycles;
  } fetch_vec_t;

  task automatic fetch_one(input fetch_vec_t v, input int idx);
    int          n;
    bit          sr_ok;
    bit          have_addr;
    bit          got;
    logic [31:0] first_addr;
    string       nm;
    nm         = $sformatf("vec%0d", idx);
    d_gnt_wait = v.gnt_wait;
    d_lat      = v.lat;
    n = 0; sr_ok = 1; have_addr = 0; got = 0; first_addr = '1;
    for (int k = 0; k < 200; k++) begin
      tick(6'b0, 1'b0, 32'h0, 1'b0);
      if (if_valid_o === 1'b1) begin
        got = 1;
        break;
      end
      n++;
      if (stallreq_from_if !== 1'b1) sr_ok = 0;
      if (mif.mem_req_o === 1'b1 && !have_addr) begin
        have_addr  = 1;
        first_addr = mif.mem_addr_o;
      end
    end
    check({nm, "_valid"}, got, 1);
    check({nm, "_pc"}, if_pc_o, v.exp_pc);
    check({nm, "_inst"}, if_inst_o, v.exp_inst);
    check({nm, "_cycles"}, n, v.exp_cycles);
    check({nm, "_stallreq"}, sr_ok, 1);
    check({nm, "_first_addr"}, first_addr, v.exp_pc);
  endtask

  // ---------------- reference model (random phase) ----------------
  logic [31:0] m_pc;
  int          m_nbytes;
  bit          m_live;
  bit          m_after_rst;
  bit          p_req_wait, p_br;
  logic [31:0] p_addr;
  int          m_handoffs;
  int          m_no_valid;

  task automatic model_step(input logic [5:0] st, input logic br,
                            input logic [31:0] tg, input logic rs);
    if (m_after_rst) begin
      check_zero("rnd_after_rst");
    end else begin
      if (if_valid_o === 1'b1) begin
        check("rnd_pc", if_pc_o, m_pc);
        check("rnd_inst", if_inst_o, word_at(m_pc));
        check("rnd_bytes_done", m_nbytes, 4);
        check("rnd_stallreq_hold", stallreq_from_if, 0);
      end
      if (mif.mem_req_o === 1'b1) begin
        check("rnd_addr", mif.mem_addr_o, m_pc + 32'(m_nbytes));
        check("rnd_stallreq_req", stallreq_from_if, !br);
      end
      check("rnd_one_outstanding",
            r_pending && !mif.mem_gnt_i && mif.mem_req_o, 0);
      if (p_req_wait && !p_br)
        check("rnd_req_stable", {mif.mem_req_o, mif.mem_addr_o}, {1'b1, p_addr});
    end

    p_req_wait  = (mif.mem_req_o === 1'b1) && !mif.mem_gnt_i;
    p_addr      = mif.mem_addr_o;
    p_br        = br;
    m_after_rst = rs;

    if (if_valid_o === 1'b1) m_no_valid = 0;
    else                     m_no_valid++;

    if (rs) begin
      m_pc     = 32'h0;
      m_nbytes = 0;
      m_live   = 0;
    end else begin
      if (mif.mem_gnt_i) m_live = !br;
      if (mif.mem_rvalid_i) begin
        if (m_live && !br) m_nbytes++;
        m_live = 0;
      end
      if (br) begin
        m_pc     = {tg[31:2], 2'b00};
        m_nbytes = 0;
        m_live   = 0;
      end else if (if_valid_o === 1'b1 && st[1:0] == 2'b00) begin
        m_pc     = m_pc + 32'd4;
        m_nbytes = 0;
        m_handoffs++;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    fetch_vec_t vecs [4];
    bit         found;
    int         rv;

    rst = 1'b1; stall = 6'b0; branch_flag_i = 1'b0; branch_target_i = 32'h0;

    for (int i = 0; i < 256; i++) mem[i] = 8'((i * 37 + 11) ^ (i >> 3));
    mem[0]  = 8'h13; mem[1]  = 8'h05; mem[2]  = 8'h10; mem[3]  = 8'h00;
    mem[4]  = 8'h93; mem[5]  = 8'h05; mem[6]  = 8'h20; mem[7]  = 8'h00;
    mem[8]  = 8'h33; mem[9]  = 8'h06; mem[10] = 8'hb5; mem[11] = 8'h00;
    mem[12] = 8'h6f; mem[13] = 8'h00; mem[14] = 8'h00; mem[15] = 8'h00;

    // each byte costs (gnt_wait+1) request cycles plus (lat+1) wait cycles
    vecs[0] = '{0, 0, 32'h0,  32'h0010_0513, 8};
    vecs[1] = '{2, 1, 32'h4,  32'h0020_0593, 20};
    vecs[2] = '{0, 2, 32'h8,  32'h00b5_0633, 16};
    vecs[3] = '{1, 0, 32'hC,  32'h0000_006f, 12};

    // Reset state
    tick(6'b0, 1'b0, 32'h0, 1'b1);
    tick(6'b0, 1'b0, 32'h0, 1'b1);
    check_zero("reset_held");
    tick(6'b0, 1'b0, 32'h0, 1'b0);
    check_zero("reset_release");

    // Table-driven back-to-back fetches
    for (int i = 0; i < 4; i++) fetch_one(vecs[i], i);

    // Stall while presenting: outputs frozen, no memory traffic
    d_gnt_wait = 0; d_lat = 0;
    wait_valid("stallA", 6'b000111, 32'h10);
    for (int k = 0; k < 3; k++) begin
      tick(6'b000111, 1'b0, 32'h0, 1'b0);
      check("stallA_hold_ctl", {mif.mem_req_o, if_valid_o}, 2'b01);
      check("stallA_hold_pc", if_pc_o, 32'h10);
      check("stallA_hold_inst", if_inst_o, word_at(32'h10));
    end
    tick(6'b000001, 1'b0, 32'h0, 1'b0);
    tick(6'b000000, 1'b0, 32'h0, 1'b0);
    check("keep_pc_represent", {if_valid_o, if_pc_o}, {1'b1, 32'h10});
    tick(6'b000000, 1'b0, 32'h0, 1'b0);
    check("stallA_next_req", {mif.mem_req_o, mif.mem_addr_o}, {1'b1, 32'h14});
    wait_valid("fetch14", 6'b0, 32'h14);

    // Grant withheld 5 cycles: request must stay put
    d_gnt_wait = 5;
    for (int k = 0; k < 6; k++) begin
      tick(6'b0, 1'b0, 32'h0, 1'b0);
      check("gnt_wait_req_stable", {mif.mem_req_o, mif.mem_addr_o}, {1'b1, 32'h18});
      check("gnt_wait_gnt", mif.mem_gnt_i, (k == 5));
    end
    d_gnt_wait = 0;
    rv = 0; found = 0;
    for (int k = 0; k < 200; k++) begin
      tick(6'b0, 1'b0, 32'h0, 1'b0);
      if (mif.mem_rvalid_i) rv++;
      if (if_valid_o === 1'b1) begin found = 1; break; end
    end
    check("gnt_wait_found", found, 1);
    check("gnt_wait_rvalids", rv, 4);
    check("gnt_wait_inst", {if_pc_o, if_inst_o}, {32'h18, word_at(32'h18)});

    // Redirect while waiting on byte 2: late byte must be drained
    d_lat = 2; found = 0;
    for (int k = 0; k < 200; k++) begin
      tick(6'b0, 1'b0, 32'h0, 1'b0);
      if (mif.mem_gnt_i && mif.mem_addr_o == 32'h1E) begin found = 1; break; end
    end
    check("drain_reach_byte2", found, 1);
    tick(6'b0, 1'b1, 32'h100, 1'b0);
    check("drain_no_rvalid_yet", mif.mem_rvalid_i, 0);
    tick(6'b0, 1'b0, 32'h0, 1'b0);
    check("drain_quiet", {mif.mem_req_o, stallreq_from_if, if_valid_o}, 3'b000);
    tick(6'b0, 1'b0, 32'h0, 1'b0);
    check("drain_late_byte", {mif.mem_rvalid_i, mif.mem_req_o}, 2'b10);
    tick(6'b0, 1'b0, 32'h0, 1'b0);
    check("drain_new_req", {mif.mem_req_o, mif.mem_addr_o}, {1'b1, 32'h100});
    d_lat = 0;
    wait_valid("fetch100", 6'b000011, 32'h100);

    // Redirect in the same cycle as a handoff: target wins, low bits dropped
    tick(6'b0, 1'b1, 32'h203, 1'b0);
    check("redir_handoff_valid", if_valid_o, 1);
    tick(6'b0, 1'b0, 32'h0, 1'b0);
    check("redir_handoff_next", {if_valid_o, mif.mem_req_o, mif.mem_addr_o},
          {1'b0, 1'b1, 32'h200});
    wait_valid("fetch200", 6'b0, 32'h200);

    // Reset in the middle of a fetch at pc=8
    tick(6'b0, 1'b1, 32'h8, 1'b0);
    found = 0;
    for (int k = 0; k < 200; k++) begin
      tick(6'b0, 1'b0, 32'h0, 1'b0);
      if (mif.mem_gnt_i && mif.mem_addr_o == 32'h9) begin found = 1; break; end
    end
    check("midrst_reach", found, 1);
    tick(6'b0, 1'b0, 32'h0, 1'b1);
    tick(6'b0, 1'b0, 32'h0, 1'b0);
    check_zero("midrst_after");
    tick(6'b0, 1'b0, 32'h0, 1'b0);
    check("midrst_restart", {mif.mem_req_o, mif.mem_addr_o}, {1'b1, 32'h0});
    wait_valid("midrst_fetch0", 6'b0, 32'h0);

    // Randomized traffic against the reference model
    rand_mode = 1;
    tick(6'b0, 1'b0, 32'h0, 1'b1);
    m_pc = 32'h0; m_nbytes = 0; m_live = 0; m_after_rst = 1;
    p_req_wait = 0; p_br = 0; p_addr = '0; m_handoffs = 0; m_no_valid = 0;
    for (int k = 0; k < 4000; k++) begin
      logic [5:0]  st;
      logic        br;
      logic        rs;
      logic [31:0] tg;
      st = ($urandom_range(0, 1) == 0) ? 6'b0 : 6'($urandom);
      br = ($urandom_range(0, 63) == 0);
      rs = ($urandom_range(0, 499) == 0);
      tg = $urandom & 32'h0000_03FF;
      tick(st, br, tg, rs);
      model_step(st, br, tg, rs);
      if (m_no_valid > 400) begin
        errors++;
        $display("FAIL rnd_liveness: no instruction for %0d cycles, required <= 400", m_no_valid);
        break;
      end
    end
    checks++;
    check("rnd_handoffs", (m_handoffs >= 20), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required earlier finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
